// File: rtl/fc_weight_fetch_seq.sv
// fc_weight_fetch_seq
// Reads FC weight pairs from a dual-port ROM that has a 1-cycle registered read.
// Each issued read fetches word 2i on port A and word 2i+1 on port B. The pairs
// stream to the MAC array over valid/ready. A 2-entry buffer absorbs the ROM
// latency, so a downstream stall loses no data.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i, abort_i     job request (sampled in idle only), job cancel (ignored in idle)
//   base_addr_i          first word address, sampled with start
//   num_words_i          word count, 0..2**AddrW, sampled with start
//   busy_o, done_o       job active, 1-cycle completion pulse
//   rom_addr_a/b_o       registered ROM addresses (b = a + 1, wrapping)
//   rom_q_a/b_i          ROM read data, valid one cycle after the address
//   w_valid_o/w_ready_i  output pair handshake
//   w_a_o, w_b_o         even / odd weight of the pair
//   w_b_valid_o          low only on the final pair of an odd-length job
//   w_last_o             final pair of the job
//
// Optional feature: define FCSEQ_STALL_CNT_EN to add stall_cnt_o[15:0]. It counts
// busy cycles with w_valid_o & ~w_ready_i, saturates, and clears on start.

module fc_weight_fetch_seq #(
  parameter int unsigned AddrW = 9,
  parameter int unsigned DataW = 16,
  parameter int unsigned LenW  = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [AddrW-1:0] base_addr_i,
  input  logic [LenW-1:0]  num_words_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [AddrW-1:0] rom_addr_a_o,
  output logic [AddrW-1:0] rom_addr_b_o,
  input  logic [DataW-1:0] rom_q_a_i,
  input  logic [DataW-1:0] rom_q_b_i,
  output logic             w_valid_o,
  input  logic             w_ready_i,
  output logic [DataW-1:0] w_a_o,
  output logic [DataW-1:0] w_b_o,
  output logic             w_b_valid_o,
  output logic             w_last_o
`ifdef FCSEQ_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt_o
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e state_q, state_d;

  logic [AddrW-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [LenW-1:0]  pairs_left_q, pairs_left_d;
  logic             odd_q, odd_d;
  logic             inflight_q, inflight_last_q;
  logic             done_q, done_d;

  // 2-entry output buffer
  logic [DataW-1:0] buf_a_q [2];
  logic [DataW-1:0] buf_b_q [2];
  logic             buf_bv_q [2];
  logic             buf_last_q [2];
  logic [1:0]       occ_q, occ_d;
  logic             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;

  logic start_ok, start_job, abort_ok;
  logic head_valid, pop, push, issue, last_issue, last_pop;
  logic push_bv;

  assign start_ok   = (state_q == StIdle) && start_i;
  assign start_job  = start_ok && (num_words_i != '0);
  assign abort_ok   = (state_q != StIdle) && abort_i;
  assign head_valid = (occ_q != 2'd0);
  assign pop        = head_valid && w_ready_i;
  assign last_pop   = pop && buf_last_q[rd_ptr_q];
  // Data returning this cycle belongs to the read issued last cycle.
  assign push       = inflight_q && !abort_ok;
  assign push_bv    = !(inflight_last_q && odd_q);

  // Issue only if the buffer is guaranteed room when the data lands next cycle.
  assign issue      = (state_q == StFetch) && !abort_i &&
                      ((3'(occ_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
  assign last_issue = issue && (pairs_left_q == LenW'(1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_job) begin
          state_d = StFetch;
        end else if (start_ok) begin
          done_d = 1'b1;  // zero-length job completes immediately
        end
      end
      StFetch: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (last_issue) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (last_pop) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o       = (state_q != StIdle);
    done_o       = done_q;
    rom_addr_a_o = addr_a_q;
    rom_addr_b_o = addr_b_q;
    w_valid_o    = head_valid;
    // Payload is forced to zero while no pair is presented.
    w_a_o        = head_valid ? buf_a_q[rd_ptr_q]    : '0;
    w_b_o        = head_valid ? buf_b_q[rd_ptr_q]    : '0;
    w_b_valid_o  = head_valid ? buf_bv_q[rd_ptr_q]   : 1'b0;
    w_last_o     = head_valid ? buf_last_q[rd_ptr_q] : 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Address / job counters and buffer bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    pairs_left_d = pairs_left_q;
    odd_d        = odd_q;
    if (start_ok) begin
      addr_a_d     = base_addr_i;
      addr_b_d     = base_addr_i + AddrW'(1);
      pairs_left_d = (num_words_i >> 1) + LenW'(num_words_i[0]);
      odd_d        = num_words_i[0];
    end else if (issue) begin
      addr_a_d     = addr_a_q + AddrW'(2);
      addr_b_d     = addr_b_q + AddrW'(2);
      pairs_left_d = pairs_left_q - LenW'(1);
    end
  end

  always_comb begin
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (abort_ok) begin
      occ_d    = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      occ_d = occ_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_a_q        <= '0;
      addr_b_q        <= '0;
      pairs_left_q    <= '0;
      odd_q           <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      occ_q           <= 2'd0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      buf_a_q[0]      <= '0;
      buf_a_q[1]      <= '0;
      buf_b_q[0]      <= '0;
      buf_b_q[1]      <= '0;
      buf_bv_q[0]     <= 1'b0;
      buf_bv_q[1]     <= 1'b0;
      buf_last_q[0]   <= 1'b0;
      buf_last_q[1]   <= 1'b0;
    end else begin
      addr_a_q        <= addr_a_d;
      addr_b_q        <= addr_b_d;
      pairs_left_q    <= pairs_left_d;
      odd_q           <= odd_d;
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
      occ_q           <= occ_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      if (push) begin
        buf_a_q[wr_ptr_q]    <= rom_q_a_i;
        // Port B of an odd job's final read is past the end; discard it.
        buf_b_q[wr_ptr_q]    <= push_bv ? rom_q_b_i : '0;
        buf_bv_q[wr_ptr_q]   <= push_bv;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
      end
    end
  end

`ifdef FCSEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_ok) begin
      stall_cnt_d = '0;
    end else if ((state_q != StIdle) && head_valid && !w_ready_i &&
                 (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fc_weight_fetch_seq.sv
`timescale 1ns/1ps
module tb_fc_weight_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [8:0]  base;
  logic [9:0]  num;
  logic        busy, done;
  logic [8:0]  rom_addr_a, rom_addr_b;
  logic [15:0] rom_q_a, rom_q_b;
  logic        w_valid, w_ready;
  logic [15:0] w_a, w_b;
  logic        w_b_valid, w_last;
`ifdef FCSEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int d0;

  logic [33:0] exp_q [$];
  logic [15:0] rom [512];
  logic        held = 1'b0;
  logic [34:0] held_val = '0;
  logic [6:0]  pat;

  always #5 clk = ~clk;

  fc_weight_fetch_seq dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .base_addr_i  (base),
    .num_words_i  (num),
    .busy_o       (busy),
    .done_o       (done),
    .rom_addr_a_o (rom_addr_a),
    .rom_addr_b_o (rom_addr_b),
    .rom_q_a_i    (rom_q_a),
    .rom_q_b_i    (rom_q_b),
    .w_valid_o    (w_valid),
    .w_ready_i    (w_ready),
    .w_a_o        (w_a),
    .w_b_o        (w_b),
    .w_b_valid_o  (w_b_valid),
    .w_last_o     (w_last)
`ifdef FCSEQ_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt)
`endif
  );

  // Dual-port ROM with 1-cycle registered read
  always @(posedge clk) begin
    rom_q_a <= rom[rom_addr_a];
    rom_q_b <= rom[rom_addr_b];
  end

  function automatic logic [15:0] rom_word(input int addr);
    return 16'((addr * 37 + 32'h1234) & 32'hFFFF);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pair stream for a job: {last, b_valid, b, a}
  task automatic push_model(input int b, input int n);
    int pairs;
    pairs = (n + 1) / 2;
    for (int k = 0; k < pairs; k++) begin
      int    aa;
      logic  lst, bv;
      logic [15:0] wb;
      aa  = (b + 2 * k) % 512;
      lst = (k == pairs - 1);
      bv  = !(lst && (n % 2 == 1));
      wb  = bv ? rom_word((aa + 1) % 512) : 16'h0;
      exp_q.push_back({lst, bv, wb, rom_word(aa)});
    end
  endtask

  // Monitor: pops the scoreboard on each handshake, checks stall stability.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1) done_cnt++;
      if (held) check("hold_stable", 64'({w_valid, w_last, w_b_valid, w_b, w_a}), 64'(held_val));
      if (w_valid === 1'b1 && w_ready === 1'b1) begin
        check("pair_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          logic [33:0] e;
          e = exp_q.pop_front();
          check("pair_data", 64'({w_last, w_b_valid, w_b, w_a}), 64'(e));
        end
      end
      held     = (w_valid === 1'b1) && (w_ready === 1'b0);
      held_val = {w_valid, w_last, w_b_valid, w_b, w_a};
    end else begin
      held = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [8:0] b, input logic [9:0] n);
    base  = b;
    num   = n;
    start = 1'b1;
    push_model(int'(b), int'(n));
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && w_valid !== 1'b1; i++) step();
    check(tag, 64'(w_valid), 64'd1);
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int i = 0; i < 200 && done_cnt < target; i++) step();
    check(tag, 64'(done_cnt), 64'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'({busy, done, w_valid, w_b_valid, w_last, rom_addr_a, rom_addr_b, w_a, w_b}),
          64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = rom_word(i);
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base = '0; num = '0; w_ready = 1'b1;
    #1;
    check_all_zero("reset_state");
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // 1: asynchronous reset in the middle of a job
    d0 = done_cnt;
    start_job(9'd0, 10'd8);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t1_async_reset");
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      check("t1_idle_busy", 64'(busy), 64'd0);
      check("t1_idle_valid", 64'(w_valid), 64'd0);
    end
    check("t1_no_done", 64'(done_cnt), 64'(d0));

    // 2: aligned job, full throughput and latency
    d0 = done_cnt;
    start_job(9'd0, 10'd8);
    check("t2_busy", 64'(busy), 64'd1);
    check("t2_valid_e0", 64'(w_valid), 64'd0);
    check("t2_addr_a", 64'(rom_addr_a), 64'd0);
    check("t2_addr_b", 64'(rom_addr_b), 64'd1);
    step();
    check("t2_valid_e1", 64'(w_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_stream_valid", 64'(w_valid), 64'd1);
    end
    step();
    check("t2_done", 64'(done), 64'd1);
    check("t2_busy_end", 64'(busy), 64'd0);
    check("t2_valid_end", 64'(w_valid), 64'd0);
    step();
    check("t2_done_pulse", 64'(done), 64'd0);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t2_done_cnt", 64'(done_cnt), 64'(d0 + 1));

    // 3: address wrap, odd length
    d0 = done_cnt;
    start_job(9'd510, 10'd5);
    check("t3_addr_a", 64'(rom_addr_a), 64'd510);
    check("t3_addr_b", 64'(rom_addr_b), 64'd511);
    wait_done(d0 + 1, "t3_done");
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);
    step();
    start_job(9'd511, 10'd4);
    check("t3_wrap_a", 64'(rom_addr_a), 64'd511);
    check("t3_wrap_b", 64'(rom_addr_b), 64'd0);
    step();
    check("t3_wrap_a2", 64'(rom_addr_a), 64'd1);
    check("t3_wrap_b2", 64'(rom_addr_b), 64'd2);
    wait_done(d0 + 2, "t3_wrap_done");
    check("t3_wrap_queue_empty", 64'(exp_q.size()), 64'd0);

    // 4: backpressure pattern 1,0,0,1,0,1,1
    d0 = done_cnt;
    step();
    w_ready = 1'b0;
    start_job(9'd64, 10'd6);
    wait_valid("t4_first_valid");
    pat = 7'b1101001;
    for (int i = 0; i < 7; i++) begin
      w_ready = pat[i];
      step();
    end
    w_ready = 1'b1;
    wait_done(d0 + 1, "t4_done");
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef FCSEQ_STALL_CNT_EN
    check("t4_stall_cnt", 64'(stall_cnt), 64'd3);
`endif

    // 5: abort one cycle after the first handshake
    d0 = done_cnt;
    step();
    start_job(9'd100, 10'd20);
    wait_valid("t5_first_valid");
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_abort_busy", 64'(busy), 64'd0);
    check("t5_abort_valid", 64'(w_valid), 64'd0);
    check("t5_popped", 64'(exp_q.size()), 64'd8);
    exp_q.delete();
    repeat (3) begin
      step();
      check("t5_quiet_valid", 64'(w_valid), 64'd0);
    end
    check("t5_no_done", 64'(done_cnt), 64'(d0));
    start_job(9'd300, 10'd7);
    wait_done(d0 + 1, "t5_restart_done");
    check("t5_restart_queue", 64'(exp_q.size()), 64'd0);

    // 6: zero-length job, start while busy, abort+start in idle
    d0 = done_cnt;
    step();
    start_job(9'd5, 10'd0);
    check("t6_zero_done", 64'(done), 64'd1);
    check("t6_zero_busy", 64'(busy), 64'd0);
    check("t6_zero_valid", 64'(w_valid), 64'd0);
    step();
    check("t6_zero_done_pulse", 64'(done), 64'd0);
    check("t6_zero_valid2", 64'(w_valid), 64'd0);
    check("t6_zero_done_cnt", 64'(done_cnt), 64'(d0 + 1));
    start_job(9'd8, 10'd4);
    step();
    base  = 9'd300;
    num   = 10'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(d0 + 2, "t6_busy_done");
    repeat (3) step();
    check("t6_ignored_busy", 64'(busy), 64'd0);
    check("t6_ignored_valid", 64'(w_valid), 64'd0);
    check("t6_ignored_queue", 64'(exp_q.size()), 64'd0);
    check("t6_ignored_done_cnt", 64'(done_cnt), 64'(d0 + 2));
    abort = 1'b1;
    base  = 9'd20;
    num   = 10'd3;
    start = 1'b1;
    push_model(20, 3);
    step();
    start = 1'b0;
    abort = 1'b0;
    check("t6_start_wins", 64'(busy), 64'd1);
    wait_done(d0 + 3, "t6_start_wins_done");
    check("t6_start_wins_queue", 64'(exp_q.size()), 64'd0);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
